instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/if_id_reg.sv | 44 ++++
 rtl/instr_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states,
// instruction field positions and fetch constants.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    BUFFERED = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam logic [31:0] PC_INC     = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority: clear > load > bubble > hold.
module if_id_reg
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= 32'h0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc4_q   <= pc4_i;
    end else if (bubble_i) begin
      // A bubble only invalidates; the stale word stays visible but unused.
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, request FSM and a one-word skid buffer that
// catches a returning word while decode is stalled.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  opcode,
  output if_state_e   dbg_state_o
);

  // Handshake: a word transfers on any rising edge where imem_req and
  // imem_ready are both 1; imem_addr stays fixed until then unless redirected.

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic        buf_valid_q, buf_valid_d;

  logic        ifid_clear;
  logic        ifid_load;
  logic        ifid_bubble;
  logic [31:0] ifid_instr_in;
  logic [31:0] ifid_pc4_in;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_INC;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    buf_valid_d   = buf_valid_q;
    ifid_clear    = 1'b0;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = pc_plus4;

    if (branch_taken) begin
      pc_d        = {branch_target[31:2], 2'b00};
      ifid_clear  = 1'b1;
      buf_valid_d = 1'b0;
      buf_instr_d = NOP;
      buf_pc4_d   = 32'h0;
      state_d     = FETCH;
    end else if (flush) begin
      ifid_clear  = 1'b1;
      buf_valid_d = 1'b0;
      buf_instr_d = NOP;
      buf_pc4_d   = 32'h0;
      state_d     = FETCH;
    end else begin
      unique case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              buf_valid_d = 1'b1;
              state_d     = BUFFERED;
            end else begin
              ifid_load = 1'b1;
            end
          end else if (!stall) begin
            ifid_bubble = 1'b1;
          end
        end
        BUFFERED: begin
          if (!stall && buf_valid_q) begin
            ifid_load     = 1'b1;
            ifid_instr_in = buf_instr_q;
            ifid_pc4_in   = buf_pc4_q;
            buf_valid_d   = 1'b0;
            state_d       = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP;
      buf_pc4_q   <= 32'h0;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (ifid_clear),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (ifid_instr_in),
    .pc4_i    (ifid_pc4_in),
    .valid_o  (ifid_valid),
    .instr_o  (ifid_instr),
    .pc4_o    (ifid_pc4)
  );

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign opcode      = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign dbg_state_o = state_q;

endmodule
